// File: rtl/game_pkg.sv
// Shared types and constants for the catch game: FSM encodings, key codes and
// playfield geometry.
package game_pkg;

  typedef enum logic [1:0] {
    StInit = 2'd0,
    StGame = 2'd1,
    StWin  = 2'd2,
    StLose = 2'd3
  } state_t;

  localparam logic [3:0] KeyLeft    = 4'd2;
  localparam logic [3:0] KeyRight   = 4'd3;
  localparam logic [3:0] KeyInvalid = 4'd4;

  localparam int unsigned LANES    = 8;
  localparam int unsigned LANE_W   = 80;
  localparam int unsigned FARMER_Y = 400;

  localparam logic [2:0] FarmerHome = 3'd3;
  localparam logic [7:0] LfsrSeed   = 8'hA5;

endpackage

// File: rtl/catch_engine_if.sv
// Player inputs and game-state outputs of the catch engine.
interface catch_engine_if;
  logic       start;
  logic       key_valid;
  logic [3:0] key_num;
  logic [1:0] state;
  logic [2:0] farmer_x;
  logic [2:0] bug_x;
  logic [9:0] bug_y;
  logic       bug_active;
  logic [6:0] score;
  logic [1:0] misses;
  logic       catch_pulse;
  logic       miss_pulse;

  modport master (
    output start, key_valid, key_num,
    input  state, farmer_x, bug_x, bug_y, bug_active, score, misses, catch_pulse, miss_pulse
  );

  modport slave (
    input  start, key_valid, key_num,
    output state, farmer_x, bug_x, bug_y, bug_active, score, misses, catch_pulse, miss_pulse
  );
endinterface

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, free-running; low OUT_W bits exposed.
module lfsr8 #(
  parameter int unsigned OUT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       seed,
  output logic [OUT_W-1:0] value
);

  logic [7:0] lfsr_q;
  logic       feedback;

  assign feedback = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];
  assign value    = lfsr_q[OUT_W-1:0];

  // An all-zero seed would lock the register at zero, so substitute 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr_q <= (seed == 8'd0) ? 8'd1 : seed;
    end else begin
      lfsr_q <= {lfsr_q[6:0], feedback};
    end
  end

endmodule

// File: rtl/catch_engine.sv
// Catch-the-bug game core: state machine, farmer movement, fall prescaler and
// catch/miss resolution.
module catch_engine
  import game_pkg::*;
#(
  parameter int unsigned TICK_DIV  = 2_500_000,
  parameter int unsigned STEP_PX   = 8,
  parameter int unsigned CATCH_Y   = 320,
  parameter int unsigned WIN_SCORE = 20,
  parameter int unsigned MAX_MISS  = 3
) (
  input logic           clk,
  input logic           rst,
  catch_engine_if.slave bus
);

  localparam int unsigned PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRESC_W-1:0] PrescLast = PRESC_W'(TICK_DIV - 1);

  state_t             state_q;
  logic [PRESC_W-1:0] presc_q;
  logic [2:0]         farmer_q;
  logic [2:0]         bug_x_q;
  logic [9:0]         bug_y_q;
  logic               bug_active_q;
  logic [6:0]         score_q;
  logic [1:0]         misses_q;
  logic               catch_q;
  logic               miss_q;

  logic       tick;
  logic       key_left;
  logic       key_right;
  logic [2:0] spawn_lane;
  logic [6:0] score_inc;
  logic [1:0] miss_inc;

  lfsr8 #(
    .OUT_W (3)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .seed  (LfsrSeed),
    .value (spawn_lane)
  );

  assign tick      = (state_q == StGame) && (presc_q == PrescLast);
  assign key_left  = bus.key_valid && (bus.key_num == KeyLeft);
  assign key_right = bus.key_valid && (bus.key_num == KeyRight);
  assign score_inc = (score_q == 7'd99) ? score_q : score_q + 7'd1;
  assign miss_inc  = (misses_q == 2'd3) ? misses_q : misses_q + 2'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StInit;
      presc_q      <= '0;
      farmer_q     <= FarmerHome;
      bug_x_q      <= 3'd0;
      bug_y_q      <= 10'd0;
      bug_active_q <= 1'b0;
      score_q      <= 7'd0;
      misses_q     <= 2'd0;
      catch_q      <= 1'b0;
      miss_q       <= 1'b0;
    end else begin
      catch_q <= 1'b0;
      miss_q  <= 1'b0;
      // start has priority over any tick or key in the same cycle.
      if (bus.start) begin
        state_q      <= (state_q == StInit) ? StGame : StInit;
        presc_q      <= '0;
        farmer_q     <= FarmerHome;
        bug_y_q      <= 10'd0;
        bug_active_q <= 1'b0;
        score_q      <= 7'd0;
        misses_q     <= 2'd0;
      end else if (state_q == StGame) begin
        presc_q <= tick ? '0 : presc_q + 1'b1;
        if (key_left && (farmer_q != 3'd0)) begin
          farmer_q <= farmer_q - 3'd1;
        end else if (key_right && (farmer_q != 3'(LANES - 1))) begin
          farmer_q <= farmer_q + 3'd1;
        end
        if (tick) begin
          if (!bug_active_q) begin
            bug_x_q      <= spawn_lane;
            bug_y_q      <= 10'd0;
            bug_active_q <= 1'b1;
          end else if (bug_y_q < 10'(CATCH_Y)) begin
            bug_y_q <= bug_y_q + 10'(STEP_PX);
          end else begin
            // Resolution compares against the pre-move farmer lane.
            bug_active_q <= 1'b0;
            if (bug_x_q == farmer_q) begin
              score_q <= score_inc;
              catch_q <= 1'b1;
              if (score_inc == 7'(WIN_SCORE)) state_q <= StWin;
            end else begin
              misses_q <= miss_inc;
              miss_q   <= 1'b1;
              if (miss_inc == 2'(MAX_MISS)) state_q <= StLose;
            end
          end
        end
      end
    end
  end

  assign bus.state       = state_q;
  assign bus.farmer_x    = farmer_q;
  assign bus.bug_x       = bug_x_q;
  assign bus.bug_y       = bug_y_q;
  assign bus.bug_active  = bug_active_q;
  assign bus.score       = score_q;
  assign bus.misses      = misses_q;
  assign bus.catch_pulse = catch_q;
  assign bus.miss_pulse  = miss_q;

endmodule

// File: tb/tb_catch_engine.sv
// Directed self-checking bench for catch_engine with a fast fall rate.
module tb_catch_engine;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  catch_engine_if bus ();

  catch_engine #(
    .TICK_DIV  (4),
    .STEP_PX   (80),
    .CATCH_Y   (320),
    .WIN_SCORE (2),
    .MAX_MISS  (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference LFSR from the polynomial, stepped every clock like the design's.
  logic [7:0] m_lfsr;
  always @(posedge clk or posedge rst) begin
    if (rst) m_lfsr <= 8'hA5;
    else     m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  logic [7:0] lfsr_before;
  logic [2:0] spawn_x;
  logic       prev_active;

  task automatic cycle();
    prev_active = bus.bug_active;
    lfsr_before = m_lfsr;
    @(posedge clk);
    #1;
    if (!prev_active && bus.bug_active) begin
      spawn_x = lfsr_before[2:0];
      n_cmp++;
      if (bus.bug_x !== spawn_x) begin
        n_fail++;
        $display("FAIL spawn_lane: got %0d want %0d", bus.bug_x, spawn_x);
      end
      n_cmp++;
      if (bus.bug_y !== 10'd0) begin
        n_fail++;
        $display("FAIL spawn_y: got %0d want 0", bus.bug_y);
      end
    end
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    cycle();
    bus.start = 1'b0;
  endtask

  task automatic press(input logic [3:0] code);
    bus.key_valid = 1'b1;
    bus.key_num   = code;
    cycle();
    bus.key_valid = 1'b0;
  endtask

  task automatic wait_spawn();
    for (int i = 0; i < 40 && !bus.bug_active; i++) cycle();
    n_cmp++;
    if (bus.bug_active !== 1'b1) begin
      n_fail++;
      $display("FAIL spawn_timeout: bug_active %b want 1", bus.bug_active);
    end
  endtask

  task automatic move_to(input logic [2:0] target);
    for (int i = 0; i < 10 && bus.farmer_x !== target; i++) begin
      press((bus.farmer_x > target) ? 4'd2 : 4'd3);
    end
  endtask

  task automatic wait_resolve(output logic got_c, output logic got_m);
    for (int i = 0; i < 40; i++) begin
      cycle();
      if (bus.catch_pulse || bus.miss_pulse) break;
    end
    got_c = bus.catch_pulse;
    got_m = bus.miss_pulse;
  endtask

  task automatic check_reset_values(input string tag);
    n_cmp++;
    if (bus.state !== 2'd0 || bus.farmer_x !== 3'd3 || bus.bug_x !== 3'd0 ||
        bus.bug_y !== 10'd0 || bus.bug_active !== 1'b0 || bus.score !== 7'd0 ||
        bus.misses !== 2'd0 || bus.catch_pulse !== 1'b0 || bus.miss_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: st=%0d fx=%0d bx=%0d by=%0d act=%b sc=%0d mi=%0d cp=%b mp=%b want 0,3,0,0,0,0,0,0,0",
               tag, bus.state, bus.farmer_x, bus.bug_x, bus.bug_y, bus.bug_active, bus.score,
               bus.misses, bus.catch_pulse, bus.miss_pulse);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.start = 1'b0;
    bus.key_valid = 1'b0;
    bus.key_num = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_values");
    rst = 1'b0;
  endtask

  task automatic test_start();
    pulse_start();
    n_cmp++;
    if (bus.state !== 2'd1 || bus.farmer_x !== 3'd3 || bus.score !== 7'd0 ||
        bus.bug_active !== 1'b0) begin
      n_fail++;
      $display("FAIL start_game: st=%0d fx=%0d sc=%0d act=%b want 1,3,0,0",
               bus.state, bus.farmer_x, bus.score, bus.bug_active);
    end
  endtask

  task automatic test_move();
    logic [2:0] want;
    for (int i = 0; i < 5; i++) begin
      press(4'd2);
      want = (i < 3) ? 3'(2 - i) : 3'd0;
      n_cmp++;
      if (bus.farmer_x !== want) begin
        n_fail++;
        $display("FAIL move_left_%0d: got %0d want %0d", i, bus.farmer_x, want);
      end
    end
    press(4'd4);
    n_cmp++;
    if (bus.farmer_x !== 3'd0) begin
      n_fail++;
      $display("FAIL invalid_key: got %0d want 0", bus.farmer_x);
    end
    bus.key_num = 4'd3;
    cycle();
    n_cmp++;
    if (bus.farmer_x !== 3'd0) begin
      n_fail++;
      $display("FAIL key_without_valid: got %0d want 0", bus.farmer_x);
    end
    press(4'd3);
    n_cmp++;
    if (bus.farmer_x !== 3'd1) begin
      n_fail++;
      $display("FAIL move_right: got %0d want 1", bus.farmer_x);
    end
  endtask

  task automatic test_catch();
    logic c, m;
    for (int d = 1; d <= 2; d++) begin
      wait_spawn();
      move_to(spawn_x);
      wait_resolve(c, m);
      n_cmp++;
      if (c !== 1'b1 || m !== 1'b0 || bus.score !== 7'(d) || bus.bug_active !== 1'b0 ||
          bus.state !== ((d == 2) ? 2'd2 : 2'd1)) begin
        n_fail++;
        $display("FAIL catch_%0d: cp=%b mp=%b sc=%0d act=%b st=%0d want 1,0,%0d,0,%0d",
                 d, c, m, bus.score, bus.bug_active, bus.state, d, (d == 2) ? 2 : 1);
      end
      cycle();
      n_cmp++;
      if (bus.catch_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL catch_pulse_width_%0d: got %b want 0", d, bus.catch_pulse);
      end
    end
    press((spawn_x == 3'd7) ? 4'd2 : 4'd3);
    repeat (8) cycle();
    n_cmp++;
    if (bus.farmer_x !== spawn_x || bus.score !== 7'd2 || bus.state !== 2'd2 ||
        bus.catch_pulse !== 1'b0) begin
      n_fail++;
      $display("FAIL win_frozen: fx=%0d sc=%0d st=%0d cp=%b want %0d,2,2,0",
               bus.farmer_x, bus.score, bus.state, bus.catch_pulse, spawn_x);
    end
  endtask

  task automatic test_miss();
    logic c, m;
    logic [2:0] target;
    pulse_start();
    n_cmp++;
    if (bus.state !== 2'd0) begin
      n_fail++;
      $display("FAIL win_to_init: got %0d want 0", bus.state);
    end
    pulse_start();
    n_cmp++;
    if (bus.state !== 2'd1 || bus.score !== 7'd0 || bus.misses !== 2'd0 ||
        bus.farmer_x !== 3'd3) begin
      n_fail++;
      $display("FAIL restart_game: st=%0d sc=%0d mi=%0d fx=%0d want 1,0,0,3",
               bus.state, bus.score, bus.misses, bus.farmer_x);
    end
    target = 3'd3;
    for (int d = 1; d <= 2; d++) begin
      wait_spawn();
      target = (spawn_x == 3'd0) ? 3'd1 : spawn_x - 3'd1;
      move_to(target);
      wait_resolve(c, m);
      n_cmp++;
      if (m !== 1'b1 || c !== 1'b0 || bus.misses !== 2'(d) || bus.bug_active !== 1'b0 ||
          bus.state !== ((d == 2) ? 2'd3 : 2'd1)) begin
        n_fail++;
        $display("FAIL miss_%0d: mp=%b cp=%b mi=%0d act=%b st=%0d want 1,0,%0d,0,%0d",
                 d, m, c, bus.misses, bus.bug_active, bus.state, d, (d == 2) ? 3 : 1);
      end
    end
    press(4'd3);
    press(4'd2);
    n_cmp++;
    if (bus.farmer_x !== target || bus.state !== 2'd3 || bus.misses !== 2'd2) begin
      n_fail++;
      $display("FAIL lose_frozen: fx=%0d st=%0d mi=%0d want %0d,3,2",
               bus.farmer_x, bus.state, bus.misses, target);
    end
  endtask

  task automatic test_start_on_tick();
    logic seen;
    pulse_start();
    pulse_start();
    wait_spawn();
    seen = 1'b0;
    for (int i = 1; i <= 19; i++) begin
      cycle();
      seen = seen | bus.catch_pulse | bus.miss_pulse;
      if (i == 8) begin
        n_cmp++;
        if (bus.bug_y !== 10'd160) begin
          n_fail++;
          $display("FAIL fall_y_mid: got %0d want 160", bus.bug_y);
        end
      end
    end
    n_cmp++;
    if (bus.bug_y !== 10'd320 || seen !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_y_bottom: y=%0d early_pulse=%b want 320,0", bus.bug_y, seen);
    end
    pulse_start();
    n_cmp++;
    if (bus.state !== 2'd0 || bus.catch_pulse !== 1'b0 || bus.miss_pulse !== 1'b0 ||
        bus.score !== 7'd0 || bus.misses !== 2'd0) begin
      n_fail++;
      $display("FAIL start_beats_tick: st=%0d cp=%b mp=%b sc=%0d mi=%0d want 0,0,0,0,0",
               bus.state, bus.catch_pulse, bus.miss_pulse, bus.score, bus.misses);
    end
    cycle();
    n_cmp++;
    if (bus.catch_pulse !== 1'b0 || bus.miss_pulse !== 1'b0 || bus.state !== 2'd0) begin
      n_fail++;
      $display("FAIL start_beats_tick_after: cp=%b mp=%b st=%0d want 0,0,0",
               bus.catch_pulse, bus.miss_pulse, bus.state);
    end
  endtask

  task automatic test_reset_midfall();
    pulse_start();
    wait_spawn();
    press(4'd3);
    repeat (7) cycle();
    n_cmp++;
    if (bus.bug_y !== 10'd160 || bus.farmer_x !== 3'd4) begin
      n_fail++;
      $display("FAIL midfall_pre: y=%0d fx=%0d want 160,4", bus.bug_y, bus.farmer_x);
    end
    #3;
    rst = 1'b1;
    #1;
    check_reset_values("async_reset");
    @(posedge clk);
    #1;
    rst = 1'b0;
    pulse_start();
    wait_spawn();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation ran past 200000 time units");
    $fatal(1);
  end

  initial begin
    spawn_x = 3'd0;
    test_reset();
    test_start();
    test_move();
    test_catch();
    test_miss();
    test_start_on_tick();
    test_reset_midfall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
